// File: rtl/ticket_change_dispenser.sv
// Ticket and change dispenser: issues ticket pulses, then greedy coin pulses, then a done pulse.
// Optional COIN_50_EN adds the 50-dollar coin to the denomination set {10,5,1}.
module ticket_change_dispenser #(
   parameter int unsigned PULSE_GAP = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] numOfTicket,
   input  logic [6:0] change,
   output logic       busy,
   output logic       ticketOut,
   output logic       coinValid,
   output logic [5:0] coinOut,
   output logic       done,
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TICKET = 3'd1,
      GAP    = 3'd2,
      CHANGE = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [2:0] GAP_LAST = (PULSE_GAP == 0) ? 3'd0 : 3'(PULSE_GAP - 1);

   state_t     state, state_n;
   logic [2:0] tcnt, tcnt_n;
   logic [6:0] ccnt, ccnt_n;
   logic [2:0] gcnt, gcnt_n;
   logic       busy_n, ticket_n, coin_valid_n, done_n;
   logic [5:0] coin_n;
   logic [5:0] coin_pick;

   // Largest enabled denomination not exceeding the remainder (never more than rem when rem>0).
   function automatic logic [5:0] pick_coin(input logic [6:0] rem);
`ifdef COIN_50_EN
      if (rem >= 7'd50) return 6'd50;
`endif
      if (rem >= 7'd10) return 6'd10;
      if (rem >= 7'd5)  return 6'd5;
      return 6'd1;
   endfunction

   function automatic state_t next_phase(input logic [2:0] t, input logic [6:0] c);
      if (t != 3'd0) return TICKET;
      if (c != 7'd0) return CHANGE;
      return DONE;
   endfunction

   assign coin_pick = pick_coin(ccnt);
   assign state_dbg = state;

   always_comb begin
      state_n      = state;
      tcnt_n       = tcnt;
      ccnt_n       = ccnt;
      gcnt_n       = gcnt;
      busy_n       = busy;
      ticket_n     = 1'b0;
      coin_valid_n = 1'b0;
      coin_n       = 6'd0;
      done_n       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               tcnt_n  = (numOfTicket > 3'd5) ? 3'd5 : numOfTicket;
               ccnt_n  = change;
               busy_n  = 1'b1;
               state_n = next_phase(numOfTicket, change);
            end
         end
         TICKET: begin
            ticket_n = 1'b1;
            tcnt_n   = tcnt - 3'd1;
            if (PULSE_GAP != 0) begin
               state_n = GAP;
               gcnt_n  = GAP_LAST;
            end else begin
               state_n = next_phase(tcnt_n, ccnt);
            end
         end
         CHANGE: begin
            // A zero remainder here cannot occur normally; exit without a coin rather than underflow.
            if (ccnt == 7'd0) begin
               state_n = DONE;
            end else begin
               coin_valid_n = 1'b1;
               coin_n       = coin_pick;
               ccnt_n       = ccnt - {1'b0, coin_pick};
               if (PULSE_GAP != 0) begin
                  state_n = GAP;
                  gcnt_n  = GAP_LAST;
               end else begin
                  state_n = next_phase(tcnt, ccnt_n);
               end
            end
         end
         GAP: begin
            if (gcnt == 3'd0) state_n = next_phase(tcnt, ccnt);
            else              gcnt_n  = gcnt - 3'd1;
         end
         DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         tcnt      <= 3'd0;
         ccnt      <= 7'd0;
         gcnt      <= 3'd0;
         busy      <= 1'b0;
         ticketOut <= 1'b0;
         coinValid <= 1'b0;
         coinOut   <= 6'd0;
         done      <= 1'b0;
      end else begin
         state     <= state_n;
         tcnt      <= tcnt_n;
         ccnt      <= ccnt_n;
         gcnt      <= gcnt_n;
         busy      <= busy_n;
         ticketOut <= ticket_n;
         coinValid <= coin_valid_n;
         coinOut   <= coin_n;
         done      <= done_n;
      end
   end

endmodule
